// File: rtl/dmem_pkg.sv
// dmem_pkg: shared funct3 codes, FSM state type and port count for the data memory arbiter
package dmem_pkg;
  localparam int NREQ = 2;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  typedef enum logic [1:0] {IDLE, ACCESS, RDWAIT} state_t;
endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: byte-lane strobes, store replication, load extract/extend and access legality
module dmem_lane_align
  import dmem_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              we,
  input  logic [1:0]        off,
  input  logic [2:0]        funct3,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rword,
  output logic [3:0]        strb,
  output logic [DATA_W-1:0] wrep,
  output logic [DATA_W-1:0] rext,
  output logic              bad
);
  logic [7:0]  b;
  logic [15:0] h;
  logic        ill;
  logic        mis;
  // lane selection follows the low address bits; size comes from funct3[1:0]
  always_comb begin
    b    = rword[{off, 3'b000} +: 8];
    h    = rword[{off[1], 4'b0000} +: 16];
    rext = funct3 == F3_B  ? {{24{b[7]}}, b} :
           funct3 == F3_H  ? {{16{h[15]}}, h} :
           funct3 == F3_BU ? {24'b0, b} :
           funct3 == F3_HU ? {16'b0, h} : rword;
    strb = funct3 == F3_B ? 4'b0001 << off :
           funct3 == F3_H ? 4'b0011 << {off[1], 1'b0} : 4'b1111;
    wrep = funct3 == F3_B ? {4{wdata[7:0]}} :
           funct3 == F3_H ? {2{wdata[15:0]}} : wdata;
    ill  = we ? funct3 > F3_W : !(funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    mis  = funct3[1:0] == 2'b01 ? off[0] :
           funct3[1:0] == 2'b10 ? |off : 1'b0;
    bad  = ill | mis;
  end
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port data memory arbiter and access sequencer; DMEM_ARB_RR_EN selects round-robin over fixed priority
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NREQ-1:0]                  req,
  input  logic [NREQ-1:0]                  we,
  input  logic [NREQ-1:0][DM_ADDRESS-1:0]  addr,
  input  logic [NREQ-1:0][DATA_W-1:0]      wdata,
  input  logic [NREQ-1:0][2:0]             funct3,
  output logic [NREQ-1:0]                  gnt,
  output logic [NREQ-1:0]                  done,
  output logic                             err,
  output logic [DATA_W-1:0]                rdata,
  output logic [DM_ADDRESS-1:0]            mem_raddr,
  output logic [DM_ADDRESS-1:0]            mem_waddr,
  output logic [DATA_W-1:0]                mem_wdata,
  output logic [3:0]                       mem_wr,
  input  logic [DATA_W-1:0]                mem_rdata
);
  state_t                st;
  logic                  port;
  logic                  lwe;
  logic [DM_ADDRESS-1:0] la;
  logic [DATA_W-1:0]     lwd;
  logic [2:0]            lf3;
  logic                  any;
  logic                  win;
  logic [3:0]            strb;
  logic [DATA_W-1:0]     wrep;
  logic [DATA_W-1:0]     rext;
  logic                  bad;
`ifdef DMEM_ARB_RR_EN
  logic                  ptr;
`endif

  dmem_lane_align #(.DATA_W(DATA_W)) u_align (
    .we(lwe), .off(la[1:0]), .funct3(lf3), .wdata(lwd), .rword(mem_rdata),
    .strb(strb), .wrep(wrep), .rext(rext), .bad(bad)
  );

  // winner selection; requests seen while done is pulsing are stale and ignored
  always_comb begin
    any = |req && !(|done);
`ifdef DMEM_ARB_RR_EN
    win = &req ? ptr : req[1];
`else
    win = !req[0];
`endif
  end

  // access sequencer: latch winner, issue memory access, report completion
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st        <= IDLE;
      port      <= 1'b0;
      lwe       <= 1'b0;
      la        <= '0;
      lwd       <= '0;
      lf3       <= '0;
      gnt       <= '0;
      done      <= '0;
      err       <= 1'b0;
      rdata     <= '0;
      mem_raddr <= '0;
      mem_waddr <= '0;
      mem_wdata <= '0;
      mem_wr    <= '0;
`ifdef DMEM_ARB_RR_EN
      ptr       <= 1'b0;
`endif
    end else begin
      gnt    <= '0;
      done   <= '0;
      err    <= 1'b0;
      mem_wr <= '0;
      case (st)
        IDLE: if (any) begin
          gnt  <= NREQ'(1) << win;
          port <= win;
          lwe  <= we[win];
          la   <= addr[win];
          lwd  <= wdata[win];
          lf3  <= funct3[win];
          if (!we[win]) mem_raddr <= {addr[win][DM_ADDRESS-1:2], 2'b00};
`ifdef DMEM_ARB_RR_EN
          ptr  <= !win;
`endif
          st   <= ACCESS;
        end
        ACCESS: if (bad || lwe) begin
          done  <= NREQ'(1) << port;
          err   <= bad;
          rdata <= '0;
          if (!bad) begin
            mem_wr    <= strb;
            mem_waddr <= {la[DM_ADDRESS-1:2], 2'b00};
            mem_wdata <= wrep;
          end
          st <= IDLE;
        end else st <= RDWAIT;
        RDWAIT: begin
          done  <= NREQ'(1) << port;
          rdata <= rext;
          st    <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: randomized self-checking bench with a byte-level memory reference model
module tb_dmem_arbiter;
  logic             clk = 1'b0;
  logic             reset;
  logic [1:0]       req, we, gnt, done;
  logic [1:0][8:0]  addr;
  logic [1:0][31:0] wdata;
  logic [1:0][2:0]  funct3;
  logic             err;
  logic [31:0]      rdata, mem_wdata, mem_rdata;
  logic [8:0]       mem_raddr, mem_waddr;
  logic [3:0]       mem_wr;
  int               total = 0;
  int               bad = 0;
  logic [7:0]       refb [512];
  logic [31:0]      mem [128];
  logic [31:0]      rd, wa, wd;
  logic [3:0]       wr;
  logic             e;
  int               n;
`ifdef DMEM_ARB_RR_EN
  logic             ptr;
`endif

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .funct3(funct3), .gnt(gnt), .done(done), .err(err), .rdata(rdata),
    .mem_raddr(mem_raddr), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .mem_wr(mem_wr), .mem_rdata(mem_rdata)
  );

  function automatic logic [7:0] seed_byte(input int i);
    return 8'(i * 37 + 11);
  endfunction

  // synchronous memory macro: read word registered from the address of the previous cycle
  initial begin
    for (int i = 0; i < 128; i++)
      mem[i] = {seed_byte(4*i+3), seed_byte(4*i+2), seed_byte(4*i+1), seed_byte(4*i)};
    forever begin
      @(posedge clk);
      mem_rdata <= mem[mem_raddr[8:2]];
      for (int b = 0; b < 4; b++)
        if (mem_wr[b]) mem[mem_waddr[8:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int sz(input logic [2:0] f);
    return f[1] ? 4 : f[0] ? 2 : 1;
  endfunction

  function automatic logic legal(input logic w, input logic [2:0] f, input logic [8:0] a);
    if (w ? f > 3'd2 : !(f inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b0;
    return (int'(a) % sz(f)) == 0;
  endfunction

  function automatic logic [31:0] ld(input logic [2:0] f, input logic [8:0] a);
    logic [31:0] v;
    v = 0;
    for (int i = sz(f) - 1; i >= 0; i--) v = (v << 8) | 32'(refb[int'(a) + i]);
    if (!f[2] && sz(f) < 4 && v[8*sz(f)-1]) v = v | (32'hFFFFFFFF << (8*sz(f)));
    return v;
  endfunction

  task automatic setp(input int p, input logic w, input logic [8:0] a, input logic [31:0] d, input logic [2:0] f);
    we[p] = w;
    addr[p] = a;
    wdata[p] = d;
    funct3[p] = f;
    req[p] = 1'b1;
  endtask

  task automatic rnd_op(input int p);
    logic [2:0] lf [5];
    logic [2:0] f;
    logic [8:0] a;
    lf = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    f = $urandom_range(0, 7) == 0 ? 3'($urandom_range(0, 7)) : lf[$urandom_range(0, 4)];
    a = 9'($urandom_range(0, 511));
    if ($urandom_range(0, 4) != 0) a = a & ~9'(sz(f) - 1);
    setp(p, 1'($urandom_range(0, 1)), a, $urandom, f);
  endtask

  // one access: predict winner, wait for gnt and done, compare against the reference model
  task automatic serve(output logic [31:0] o_rd, output logic [3:0] o_wr, output logic [31:0] o_wa,
                       output logic [31:0] o_wd, output logic o_e);
    int k, w, lat;
    logic lg;
    logic [31:0] ew;
`ifdef DMEM_ARB_RR_EN
    w = req == 2'b11 ? int'(ptr) : int'(!req[0]);
`else
    w = int'(!req[0]);
`endif
    k = 0;
    do begin step(); k++; end while (gnt == 2'b00 && k < 12);
    chk("gnt", 32'(gnt), 32'(1) << w);
`ifdef DMEM_ARB_RR_EN
    ptr = (w == 0);
`endif
    lg = legal(we[w], funct3[w], addr[w]);
    lat = (lg && !we[w]) ? 2 : 1;
    k = 0;
    do begin
      step();
      k++;
      if (k == 1) chk("gnt_pulse", 32'(gnt), 32'd0);
      if (done == 2'b00) chk("idle_wr", 32'(mem_wr), 32'd0);
    end while (done == 2'b00 && k < 6);
    chk("latency", 32'(k), 32'(lat));
    chk("done", 32'(done), 32'(1) << w);
    chk("err", 32'(err), 32'(!lg));
    if (lg && we[w]) begin
      ew = sz(funct3[w]) == 1 ? {4{wdata[w][7:0]}} : sz(funct3[w]) == 2 ? {2{wdata[w][15:0]}} : wdata[w];
      chk("strobe", 32'(mem_wr), 32'(((1 << sz(funct3[w])) - 1) << addr[w][1:0]));
      chk("waddr", 32'(mem_waddr), 32'({addr[w][8:2], 2'b00}));
      chk("wdata", mem_wdata, ew);
      for (int i = 0; i < sz(funct3[w]); i++) refb[int'(addr[w]) + i] = wdata[w][8*i +: 8];
    end else begin
      chk("no_wr", 32'(mem_wr), 32'd0);
      chk("rdata", rdata, lg ? ld(funct3[w], addr[w]) : 32'd0);
    end
    o_rd = rdata;
    o_wr = mem_wr;
    o_wa = 32'(mem_waddr);
    o_wd = mem_wdata;
    o_e = err;
    step();
    req[w] = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    req = '0;
    we = '0;
    addr = '0;
    wdata = '0;
    funct3 = '0;
    for (int i = 0; i < 512; i++) refb[i] = seed_byte(i);
`ifdef DMEM_ARB_RR_EN
    ptr = 1'b0;
`endif
    repeat (2) step();
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_wr", 32'(mem_wr), 32'd0);
    chk("rst_raddr", 32'(mem_raddr), 32'd0);
    chk("rst_waddr", 32'(mem_waddr), 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    reset = 1'b0;
    step();
    setp(0, 1'b1, 9'h004, 32'hDEADBEEF, 3'b010); serve(rd, wr, wa, wd, e);
    chk("sw_wr", 32'(wr), 32'hF);
    setp(0, 1'b0, 9'h004, 32'h0, 3'b010); serve(rd, wr, wa, wd, e);
    chk("lw_data", rd, 32'hDEADBEEF);
    setp(0, 1'b1, 9'h008, 32'h80FF7F01, 3'b010); serve(rd, wr, wa, wd, e);
    setp(0, 1'b0, 9'h009, 32'h0, 3'b000); serve(rd, wr, wa, wd, e);
    chk("lb_9", rd, 32'h0000007F);
    setp(0, 1'b0, 9'h00B, 32'h0, 3'b000); serve(rd, wr, wa, wd, e);
    chk("lb_b", rd, 32'hFFFFFF80);
    setp(0, 1'b0, 9'h00B, 32'h0, 3'b100); serve(rd, wr, wa, wd, e);
    chk("lbu_b", rd, 32'h00000080);
    setp(0, 1'b0, 9'h00A, 32'h0, 3'b001); serve(rd, wr, wa, wd, e);
    chk("lh_a", rd, 32'hFFFF80FF);
    setp(0, 1'b1, 9'h00E, 32'h000000AB, 3'b000); serve(rd, wr, wa, wd, e);
    chk("sb_wr", 32'(wr), 32'h4);
    chk("sb_wdata", wd, 32'hABABABAB);
    chk("sb_waddr", wa, 32'h00C);
    setp(0, 1'b1, 9'h00E, 32'h00001234, 3'b001); serve(rd, wr, wa, wd, e);
    chk("sh_wr", 32'(wr), 32'hC);
    setp(0, 1'b0, 9'h006, 32'h0, 3'b010); serve(rd, wr, wa, wd, e);
    chk("lw_mis_err", 32'(e), 32'd1);
    chk("lw_mis_rd", rd, 32'd0);
    setp(1, 1'b1, 9'h005, 32'h5555, 3'b001); serve(rd, wr, wa, wd, e);
    chk("sh_mis_err", 32'(e), 32'd1);
    chk("sh_mis_wr", 32'(wr), 32'd0);
    for (int k = 0; k < 8; k++) begin
      for (int p = 0; p < 2; p++)
        if (!req[p]) setp(p, 1'b0, 9'($urandom_range(0, 127) * 4), 32'h0, 3'b010);
      serve(rd, wr, wa, wd, e);
    end
    if (req[0]) serve(rd, wr, wa, wd, e);
    if (req[1]) serve(rd, wr, wa, wd, e);
    setp(0, 1'b0, 9'h010, 32'h0, 3'b010);
    n = 0;
    do begin step(); n++; end while (gnt == 2'b00 && n < 12);
    chk("mid_gnt", 32'(gnt), 32'd1);
    step();
    reset = 1'b1;
    #1;
    chk("mid_rst_gnt", 32'(gnt), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_err", 32'(err), 32'd0);
    chk("mid_rst_rdata", rdata, 32'd0);
    chk("mid_rst_wr", 32'(mem_wr), 32'd0);
    chk("mid_rst_raddr", 32'(mem_raddr), 32'd0);
    chk("mid_rst_waddr", 32'(mem_waddr), 32'd0);
    chk("mid_rst_wdata", mem_wdata, 32'd0);
    req = '0;
`ifdef DMEM_ARB_RR_EN
    ptr = 1'b0;
`endif
    for (int k = 0; k < 3; k++) begin
      step();
      chk("mid_rst_nodone", 32'(done), 32'd0);
    end
    reset = 1'b0;
    step();
    setp(0, 1'b0, 9'h004, 32'h0, 3'b010); serve(rd, wr, wa, wd, e);
    chk("post_rst_lw", rd, 32'hDEADBEEF);
    for (int it = 0; it < 300; it++) begin
      for (int p = 0; p < 2; p++)
        if (!req[p] && $urandom_range(0, 2) != 0) rnd_op(p);
      if (req == 2'b00) rnd_op(int'($urandom_range(0, 1)));
      serve(rd, wr, wa, wd, e);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Arbitrates the single-ported data memory between two requesters: port 0 (core load/store unit) and port 1 (DMA/debug). Sequences each access through a small FSM. Generates word-aligned addresses and per-byte write strobes for SB/SH/SW, and extracts and extends load data for LB/LH/LW/LBU/LHU. Sits between the requesters and the data memory macro, whose read data is valid one cycle after the read address is presented.

## Interface
- DM_ADDRESS, 9, byte address width
- DATA_W, 32, data width (fixed at 32; lane logic assumes 4 bytes)
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- req  in  [1:0]  access request per port, level, held until done
- we  in  [1:0]  1 = store, 0 = load
- addr  in  [1:0][DM_ADDRESS-1:0]  byte address per port
- wdata  in  [1:0][DATA_W-1:0]  store data per port, lane 0 aligned
- funct3  in  [1:0][2:0]  RISC-V size/sign code per port
- gnt  out  [1:0]  one-cycle pulse: request accepted
- done  out  [1:0]  one-cycle pulse: access complete, rdata/err valid
- err  out  1  qualifies done: misaligned or illegal funct3
- rdata  out  DATA_W  extended load data, valid with done
- mem_raddr  out  DM_ADDRESS  word-aligned read address
- mem_waddr  out  DM_ADDRESS  word-aligned write address
- mem_wdata  out  DATA_W  lane-replicated store data
- mem_wr  out  4  byte write strobes
- mem_rdata  in  DATA_W  memory read word, valid one cycle after mem_raddr

## Operation
- States: IDLE, ACCESS, RDWAIT.
- IDLE: if any req, select a winner, pulse gnt[winner], and latch we/addr/wdata/funct3. If the latched request is legal, go to ACCESS; otherwise go to ACCESS with the error flag set.
- ACCESS, legal store: drive mem_waddr = {addr[8:2],2'b00}, mem_wr, and mem_wdata; pulse done; go to IDLE.
- ACCESS, legal load: drive mem_raddr = {addr[8:2],2'b00}; go to RDWAIT.
- ACCESS, error: mem_wr = 0, pulse done with err = 1 and rdata = 0; go to IDLE.
- RDWAIT: extract the lane from mem_rdata, extend it, pulse done with rdata; go to IDLE.
- Store strobes:
  - SW: 4'b1111, data wd.
  - SH: 4'b0011 << (2*addr[1]), data {2{wd[15:0]}}.
  - SB: 4'b0001 << addr[1:0], data {4{wd[7:0]}}.
- Load extract: byte = mem_rdata[8*addr[1:0] +: 8]; half = mem_rdata[16*addr[1] +: 16].
  - LB/LH: sign-extended.
  - LBU/LHU: zero-extended.
  - LW: whole word.
- Legal funct3: 000, 001, 010, 100, 101 for loads; 000, 001, 010 for stores. Anything else is an error.
- Misaligned (error): half with addr[0] = 1; word with addr[1:0] != 0.
- A requester holds req and its fields until its done; it drops req the cycle after done or presents a new request.
- Outputs outside the active state: mem_wr = 0 in every state except a legal-store ACCESS.

## Timing
- Reset values: state IDLE, RR pointer favours port 0, and gnt, done, err, rdata, mem_raddr, mem_waddr, mem_wdata, mem_wr all 0.
- Latency from the gnt cycle:
  - Store: done at +1.
  - Load: done at +2.
  - Error: done at +1.
- Throughput: the next gnt can be issued no earlier than the cycle after done (IDLE re-entered).
- Both requests in the same IDLE cycle: the RR pointer picks the winner; after each grant the pointer moves to the other port.
- The port not granted waits with req held; no starvation beyond one access.
- req dropped after gnt: the access still completes from latched values.
- Reset asserted mid-access: immediate return to IDLE, mem_wr forced 0 asynchronously, in-flight access discarded, no done.

## Configuration
- DMEM_ARB_RR_EN defined: round-robin arbitration as above.
- DMEM_ARB_RR_EN undefined: fixed priority, port 0 always wins simultaneous requests, no pointer flop.

## Structure
- Package dmem_pkg holds:
  - funct3 localparams F3_B, F3_H, F3_W, F3_BU, F3_HU;
  - the state enum type;
  - the port-count constant NREQ = 2.
- Sub-module dmem_lane_align (combinational) computes:
  - store strobes and replicated data;
  - the load extract/extend;
  - the misalign/illegal flag.
- The FSM, latches and arbiter live in dmem_arbiter.

## Test plan
- Port 0 SW addr 0x004 wdata 0xDEADBEEF, then LW 0x004 -> mem_wr 1111 at gnt+1; rdata 0xDEADBEEF with done at gnt+2.
- Memory word 0x80FF7F01 at 0x008:
  - LB 0x009 -> 0x0000007F.
  - LB 0x00B -> 0xFFFFFF80.
  - LBU 0x00B -> 0x00000080.
  - LH 0x00A -> 0xFFFF80FF.
- SB 0x00E wdata 0x000000AB -> mem_wr 0100, mem_wdata 0xABABABAB, mem_waddr 0x00C. SH 0x00E -> mem_wr 1100.
- LW 0x006 and SH 0x005 -> done at gnt+1 with err = 1, rdata 0, mem_wr stays 0000.
- Both ports request continuously:
  - With DMEM_ARB_RR_EN defined: gnt alternates 01, 10, 01, ...
  - With it undefined: port 1 is granted only when req[0] = 0.
- Reset asserted in RDWAIT -> no done, all outputs 0, next request granted normally after release.
